// File: rtl/hex_disp_scan.sv
// N-digit multiplexed common-anode 7-segment hex driver with double-buffered load,
// leading-zero suppression and anti-ghost dead time. Optional blinking via DISP_BLINK_EN.
module hex_disp_scan #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYC     = 64,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] hex_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                lz_en,
`ifdef DISP_BLINK_EN
  input  logic [DIGITS-1:0]   blink_mask,
`endif
  output logic [DIGITS-1:0]   an,
  output logic [7:0]          seg,
  output logic                pending,
  output logic                frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] PRE_DIV  = DIV_W'(REFRESH_DIV - 2);
  localparam logic [DIV_W-1:0] DEAD_END = DIV_W'(DEAD_CYC);

  logic [DIV_W-1:0]    div;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_hex, active_hex;
  logic [DIGITS-1:0]   shadow_dp, active_dp;
  logic [DIGITS-1:0]   shadow_blank, active_blank;

  logic                slot_end, wrap, pre_wrap;
  logic [DIGITS-1:0]   lz_sup, dark, an_next;
  logic                run;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_dark, lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0:    hex_to_seg = 7'h40;
      4'h1:    hex_to_seg = 7'h79;
      4'h2:    hex_to_seg = 7'h24;
      4'h3:    hex_to_seg = 7'h30;
      4'h4:    hex_to_seg = 7'h19;
      4'h5:    hex_to_seg = 7'h12;
      4'h6:    hex_to_seg = 7'h02;
      4'h7:    hex_to_seg = 7'h78;
      4'h8:    hex_to_seg = 7'h00;
      4'h9:    hex_to_seg = 7'h10;
      4'hA:    hex_to_seg = 7'h08;
      4'hB:    hex_to_seg = 7'h03;
      4'hC:    hex_to_seg = 7'h46;
      4'hD:    hex_to_seg = 7'h21;
      4'hE:    hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign slot_end = (div == LAST_DIV);
  assign wrap     = slot_end && (idx == LAST_IDX);
  // frame_done is registered one cycle early so it is high during the wrap cycle itself
  assign pre_wrap = (div == PRE_DIV) && (idx == LAST_IDX);

`ifdef DISP_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0] frame_cnt;
  logic            blink_on;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (wrap) begin
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end
`endif

  always_comb begin
    lz_sup = '0;
    run    = lz_en;
    // Suppression runs from the top digit down and stops at the first non-zero nibble
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run       = run && (active_hex[4*k +: 4] == 4'h0);
      lz_sup[k] = run;
    end
    dark = active_blank | lz_sup;
`ifdef DISP_BLINK_EN
    if (!blink_on) dark = dark | blink_mask;
`endif
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib  = active_hex[4*k +: 4];
        cur_dp   = active_dp[k];
        cur_dark = dark[k];
      end
    end
    lit = (div >= DEAD_END) && !cur_dark;
    for (int k = 0; k < DIGITS; k++) begin
      an_next[k] = !(lit && (idx == IDX_W'(k)));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div          <= '0;
      idx          <= '0;
      shadow_hex   <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      active_hex   <= '0;
      active_dp    <= '0;
      active_blank <= '0;
      pending      <= 1'b0;
      frame_done   <= 1'b0;
      an           <= '1;
      seg          <= 8'hFF;
    end else begin
      frame_done <= pre_wrap;
      if (slot_end) begin
        div <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end else begin
        div <= div + DIV_W'(1);
      end
      if (load) begin
        shadow_hex   <= hex_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end
      // A load landing on the wrap edge is transferred next frame; the old shadow goes now
      if (wrap && pending) begin
        active_hex   <= shadow_hex;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      if (load)      pending <= 1'b1;
      else if (wrap) pending <= 1'b0;
      an  <= an_next;
      seg <= lit ? {~cur_dp, hex_to_seg(cur_nib)} : 8'hFF;
    end
  end

endmodule

// File: tb/tb_hex_disp_scan.sv
// Directed scoreboard bench for hex_disp_scan: expected per-slot display pushed when
// data is loaded, popped as each digit slot is scanned out.
module tb_hex_disp_scan;

  localparam int DIGITS       = 4;
  localparam int REFRESH_DIV  = 4;
  localparam int DEAD_CYC     = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LAST   = DIGITS * REFRESH_DIV - 1;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  dp_in, blank_in;
  logic        lz_en;
  logic [3:0]  blink_mask;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        pending, frame_done;

  slot_t       exp_q[$];
  slot_t       held;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] cur_hex;
  logic [3:0]  cur_dp, cur_blank;

  hex_disp_scan #(
    .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYC(DEAD_CYC), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .hex_in(hex_in), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en),
`ifdef DISP_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .an(an), .seg(seg), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected appearance of each digit for the data the bench believes is active
  task automatic push_frame(input logic [3:0] blink_dark);
    int    msd;
    logic  dk;
    logic [3:0] nib;
    slot_t ent;
    msd = 0;
    for (int k = 0; k < DIGITS; k++) if (cur_hex[4*k +: 4] != 4'h0) msd = k;
    for (int k = 0; k < DIGITS; k++) begin
      nib = cur_hex[4*k +: 4];
      dk  = cur_blank[k] || (lz_en && (k > msd)) || blink_dark[k];
      ent.an  = dk ? 4'hF : ~(4'b0001 << k);
      ent.seg = dk ? 8'hFF : {~cur_dp[k], SEG_TBL[nib]};
      exp_q.push_back(ent);
    end
  endtask

  task automatic check_range(input int first, input int last);
    int s, c;
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      load = 1'b0;
      s = i / REFRESH_DIV;
      c = i % REFRESH_DIV;
      if (c == 0) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("[TB] FAIL scoreboard_empty: got 0 entries expected >0 at slot %0d", s);
        end
        held = (exp_q.size() > 0) ? exp_q.pop_front() : slot_t'({4'hF, 8'hFF});
      end
      if (c < DEAD_CYC) begin
        check_output($sformatf("an_dead s%0d c%0d", s, c), {4'h0, an}, 8'h0F);
      end else begin
        check_output($sformatf("an s%0d c%0d", s, c), {4'h0, an}, {4'h0, held.an});
        check_output($sformatf("seg s%0d c%0d", s, c), seg, held.seg);
      end
      check_output($sformatf("frame_done s%0d c%0d", s, c), {7'h0, frame_done},
                   {7'h0, (s == DIGITS - 1) && (c == REFRESH_DIV - 2)});
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    hex_in   = h;
    dp_in    = d;
    blank_in = b;
    load     = 1'b1;
  endtask

  // Mid-frame load: rest of the current frame unchanged, new data from the next frame
  task automatic load_mid_frame(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b);
    push_frame(4'h0);
    check_range(0, 3);
    apply_stimulus(h, d, b);
    check_range(4, 7);
    check_output("pending_after_load", {7'h0, pending}, 8'h01);
    check_range(8, FRAME_LAST);
    check_output("pending_after_wrap", {7'h0, pending}, 8'h00);
    cur_hex   = h;
    cur_dp    = d;
    cur_blank = b;
    push_frame(4'h0);
    check_range(0, FRAME_LAST);
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;
    lz_en = 1'b0; blink_mask = '0;
    cur_hex = '0; cur_dp = '0; cur_blank = '0;
    held = '{4'hF, 8'hFF};

    repeat (3) @(negedge clk);
    check_output("reset_an", {4'h0, an}, 8'h0F);
    check_output("reset_seg", seg, 8'hFF);
    check_output("reset_pending", {7'h0, pending}, 8'h00);
    check_output("reset_frame_done", {7'h0, frame_done}, 8'h00);
    rst = 1'b1;
    push_frame(4'h0);
    check_range(0, FRAME_LAST);

    load_mid_frame(16'h12AF, 4'b0000, 4'b0000);
    load_mid_frame(16'h9C3B, 4'b0101, 4'b0010);

    lz_en = 1'b1;
    load_mid_frame(16'h0005, 4'b0000, 4'b0000);
    load_mid_frame(16'h0000, 4'b0000, 4'b0000);
    load_mid_frame(16'h00A0, 4'b1100, 4'b0000);
    lz_en = 1'b0;
    push_frame(4'h0);
    check_range(0, FRAME_LAST);

    // Back-to-back loads: the second one wins
    push_frame(4'h0);
    check_range(0, 3);
    apply_stimulus(16'h3333, 4'b0000, 4'b0000);
    check_range(4, 4);
    apply_stimulus(16'hE7D6, 4'b0010, 4'b0000);
    check_range(5, FRAME_LAST);
    check_output("pending_b2b", {7'h0, pending}, 8'h00);
    cur_hex = 16'hE7D6; cur_dp = 4'b0010; cur_blank = 4'b0000;
    push_frame(4'h0);
    check_range(0, FRAME_LAST);

    // Load in the frame_done cycle: older shadow transfers, newer one stays pending
    push_frame(4'h0);
    check_range(0, 3);
    apply_stimulus(16'h4851, 4'b0001, 4'b0000);
    check_range(4, FRAME_LAST - 1);
    apply_stimulus(16'hB60F, 4'b1000, 4'b0000);
    check_range(FRAME_LAST, FRAME_LAST);
    check_output("pending_wrap_load", {7'h0, pending}, 8'h01);
    cur_hex = 16'h4851; cur_dp = 4'b0001; cur_blank = 4'b0000;
    push_frame(4'h0);
    check_range(0, FRAME_LAST);
    check_output("pending_second_transfer", {7'h0, pending}, 8'h00);
    cur_hex = 16'hB60F; cur_dp = 4'b1000;
    push_frame(4'h0);
    check_range(0, FRAME_LAST);

    // Reset mid-slot with a load still pending
    push_frame(4'h0);
    check_range(0, 0);
    apply_stimulus(16'h7777, 4'b0000, 4'b0000);
    check_range(1, 1);
    rst = 1'b0;
    #1;
    check_output("midreset_an", {4'h0, an}, 8'h0F);
    check_output("midreset_seg", seg, 8'hFF);
    check_output("midreset_pending", {7'h0, pending}, 8'h00);
    check_output("midreset_frame_done", {7'h0, frame_done}, 8'h00);
    exp_q.delete();
    cur_hex = '0; cur_dp = '0; cur_blank = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_frame(4'h0);
    check_range(0, FRAME_LAST);
    push_frame(4'h0);
    check_range(0, FRAME_LAST);

`ifdef DISP_BLINK_EN
    blink_mask = 4'b0001;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int f = 0; f < 5; f++) begin
      push_frame(((f / BLINK_FRAMES) % 2 == 1) ? 4'b0001 : 4'b0000);
      check_range(0, FRAME_LAST);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
